inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Instruction-side responder for the OpenMIPS core: answers the core's instruction-fetch port (chip enable, byte address, same-cycle instruction word) from an internal word array. The array is filled at run time through a byte-serial valid/ready load port. While a load is in progress the block holds the core in reset and releases it when the load completes. It sits at SoC level between the core's ROM port and a host/UART byte source.

## Interface
- `ADDR_WIDTH`, default 10, word-address bits; array depth is 2^ADDR_WIDTH words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  fetch enable from the core.
- `addr`  in  32  fetch byte address from the core.
- `inst`  out  32  instruction word to the core (combinational).
- `ld_start`  in  1  one-cycle pulse that starts or restarts a program load.
- `ld_byte`  in  8  load data byte.
- `ld_valid`  in  1  load byte valid.
- `ld_last`  in  1  qualifies `ld_byte` as the final byte of the program.
- `ld_ready`  out  1  block can accept a byte.
- `ld_done`  out  1  one-cycle pulse when a load completes.
- `core_rst`  out  1  reset to the core, active-high.
- `ld_ovf`  out  1  sticky: bytes were dropped because the array was full.
- `fetch_err`  out  1  sticky: out-of-range or misaligned fetch.

## Operation
- States are IDLE, LOAD and RUN. Reset forces IDLE.
- Reset values:
  - `ld_ready` = 0, `ld_done` = 0, `core_rst` = 1, `ld_ovf` = 0, `fetch_err` = 0.
  - Word pointer = 0, byte count = 0.
  - Array contents are not cleared.
- State transitions:
  - IDLE -> LOAD on `ld_start`.
  - LOAD -> RUN when the `ld_last` byte is accepted.
  - RUN -> LOAD on `ld_start`.
  - `ld_start` in LOAD restarts the load: pointer and count are cleared and any partially assembled word is discarded.
- `ld_ready` = 1 exactly when the state is LOAD. A byte is accepted when `ld_valid` and `ld_ready` are both high.
- Byte assembly is big-endian:
  - Byte 0 goes to bits 31:24, byte 3 to bits 7:0.
  - On the 4th byte, the assembled word is written to `mem[ptr]` and `ptr` increments.
- When `ld_last` is accepted on byte k<3, the unfilled low bytes are padded with 0x00 and the word is written.
- Overflow: once `ptr` has passed 2^ADDR_WIDTH−1, further whole words are dropped and `ld_ovf` is set. There is no wrap.
- `core_rst` is 1 in IDLE and LOAD and 0 in RUN.
- Fetch path:
  - When `ce`=0, `inst` = 0x00000000.
  - Otherwise `inst` = `mem[addr[ADDR_WIDTH+1:2]]`.
  - If `addr[31:ADDR_WIDTH+2]` ≠ 0 or `addr[1:0]` ≠ 0, `inst` = 0 (a nop) and `fetch_err` is set on the edge.
- `ld_start` coinciding with an accepted byte: `ld_start` wins and the byte is discarded.
- Sticky flags clear only on `rst` or `ld_start`.

## Timing
- Fetch latency is 0 cycles: `inst` depends combinationally on `ce`/`addr` and the array.
- An array write at edge N is visible on `inst` from cycle N+1. There is no write-to-read bypass.
- `ld_start` sampled at edge N: `ld_ready`=1 and `core_rst`=1 from cycle N+1.
- Final byte accepted at edge N:
  - `ld_ready`=0, `ld_done`=1 and `core_rst`=0 in cycle N+1.
  - `ld_done`=0 from N+2.
- Throughput is one byte per cycle with `ld_valid` held high.
- Asserting `rst` mid-load returns to IDLE immediately (asynchronously). Already-written words stay in the array. A partially assembled word is lost.

## Structure
- Constants go in `defines.v`:
  - `RstEnable`, `ChipEnable`, `ZeroWord`.
  - `InstMemNumLog2` (the default for ADDR_WIDTH).
  - State encodings `LdIdle`, `LdLoad`, `LdRun`.
- One sub-module, `byte_word_packer`, holds the byte counter, shift/assemble register and pad-on-last logic. It outputs `word` and a `word_we` strobe.
- The top level holds the FSM, pointer, array, fetch mux and flags.

## Test plan
- Reset then `ld_start`, bytes 34 01 00 01 with `ld_last` on the 4th byte:
  - `mem[0]` = 0x34010001.
  - `ld_done` pulses once.
  - `core_rst` falls the same cycle.
  - `ce`=1, `addr`=0 gives `inst` = 0x34010001.
- Load 9 bytes (01..09, `ld_last` on 09):
  - `mem[0]` = 0x01020304, `mem[1]` = 0x05060708, `mem[2]` = 0x09000000.
  - `addr`=8 returns 0x09000000.
- `ld_valid` toggling every other cycle: all bytes accepted only when `ld_ready`=1. The result is identical to the back-to-back load.
- Fetches:
  - `addr`=0x00001000 (out of range, ADDR_WIDTH=10) → `inst`=0 and `fetch_err`=1.
  - `addr`=0x2 → `inst`=0 and `fetch_err`=1.
  - `ce`=0 → `inst`=0.
- Overflow with ADDR_WIDTH=2: load 5 words → words 0..3 stored, 5th dropped, `ld_ovf`=1, `ld_done` still pulses.
- `rst` asserted after 6 bytes of a load:
  - Immediately `core_rst`=1, `ld_ready`=0, state IDLE.
  - `mem[0]` is retained.
  - A new `ld_start` restarts at pointer 0.
- `ld_start` asserted together with an accepted byte in LOAD: the byte is discarded and the pointer is 0.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and the loader state type for the instruction ROM loader.
// Imported by the byte packer and the loader top level.
package inst_rom_loader_pkg;

  localparam logic        RstEnable      = 1'b1;
  localparam logic        ChipEnable     = 1'b1;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam int          InstMemNumLog2 = 10;

  typedef enum logic [1:0] {
    LdIdle = 2'd0,
    LdLoad = 2'd1,
    LdRun  = 2'd2
  } ld_state_t;

endpackage

// File: rtl/inst_rom_loader_byte_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; a last byte
// before the fourth flushes the word with zero padding in the low bytes.
module byte_word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic        byte_last,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_we
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  // the byte being accepted completes the word in the same cycle
  always_comb begin
    word = ZeroWord;
    unique case (cnt)
      2'd0:    word = {byte_in, 24'h000000};
      2'd1:    word = {acc[23:16], byte_in, 16'h0000};
      2'd2:    word = {acc[23:8], byte_in, 8'h00};
      default: word = {acc, byte_in};
    endcase
  end

  assign word_we = byte_vld && (byte_last || (cnt == 2'd3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      cnt <= 2'd0;
      acc <= 24'h000000;
    end else if (clr) begin
      cnt <= 2'd0;
      acc <= 24'h000000;
    end else if (word_we) begin
      cnt <= 2'd0;
      acc <= 24'h000000;
    end else if (byte_vld) begin
      cnt <= cnt + 2'd1;
      unique case (cnt)
        2'd0:    acc[23:16] <= byte_in;
        2'd1:    acc[15:8]  <= byte_in;
        default: acc[7:0]   <= byte_in;
      endcase
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-fetch responder backed by a run-time loadable word array;
// holds the core in reset while a byte-serial program load is in progress.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = InstMemNumLog2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic        ld_start,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        core_rst,
  output logic        ld_ovf,
  output logic        fetch_err
);

  localparam int Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ld_state_t             state, state_nxt;
  logic [ADDR_WIDTH:0]   ptr;
  logic [31:0]           mem [Depth];
  logic                  accept;
  logic                  done_nxt;
  logic                  word_we;
  logic [31:0]           word;
  logic                  fetch_bad;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // ld_start wins over a coincident byte
  assign accept = ld_valid && (state == LdLoad) && !ld_start;

  byte_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (ld_start),
    .byte_vld (accept),
    .byte_last(ld_last),
    .byte_in  (ld_byte),
    .word     (word),
    .word_we  (word_we)
  );

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    core_rst  = 1'b1;
    done_nxt  = 1'b0;
    unique case (state)
      LdIdle: if (ld_start) state_nxt = LdLoad;
      LdLoad: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          state_nxt = LdLoad;
        end else if (accept && ld_last) begin
          state_nxt = LdRun;
          done_nxt  = 1'b1;
        end
      end
      LdRun: begin
        core_rst = 1'b0;
        if (ld_start) state_nxt = LdLoad;
      end
      default: state_nxt = LdIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state     <= LdIdle;
      ptr       <= '0;
      ld_done   <= 1'b0;
      ld_ovf    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      ld_done <= done_nxt;
      if (ld_start) begin
        ptr       <= '0;
        ld_ovf    <= 1'b0;
        fetch_err <= 1'b0;
      end else begin
        // ptr saturates one past the top; the MSB marks a full array
        if (word_we) begin
          if (ptr[ADDR_WIDTH]) ld_ovf <= 1'b1;
          else                 ptr    <= ptr + PtrOne;
        end
        if ((ce == ChipEnable) && fetch_bad) fetch_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_we && !ptr[ADDR_WIDTH]) mem[ptr[ADDR_WIDTH-1:0]] <= word;
  end

  assign fetch_bad = (addr[31:ADDR_WIDTH+2] != '0) || (addr[1:0] != 2'b00);
  assign rd_idx    = addr[ADDR_WIDTH+1:2];
  assign inst      = ((ce == ChipEnable) && !fetch_bad) ? mem[rd_idx] : ZeroWord;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a default-depth instance and a
// 4-word instance share all inputs so overflow can be observed on the small one.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_valid = 1'b0;
  logic        ld_last = 1'b0;

  logic [31:0] inst, inst_s;
  logic        ld_ready, ld_done, core_rst, ld_ovf, fetch_err;
  logic        ld_ready_s, ld_done_s, core_rst_s, ld_ovf_s, fetch_err_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .core_rst(core_rst),
    .ld_ovf(ld_ovf), .fetch_err(fetch_err)
  );

  inst_rom_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_s),
    .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(ld_ready_s), .ld_done(ld_done_s), .core_rst(core_rst_s),
    .ld_ovf(ld_ovf_s), .fetch_err(fetch_err_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_byte  = b;
    ld_valid = 1'b1;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
    ce   = 1'b1;
    addr = a;
    @(negedge clk);
    chk32(tag, inst, exp);
  endtask

  task automatic fetch_s(input logic [31:0] a, input logic [31:0] exp, input string tag);
    ce   = 1'b1;
    addr = a;
    @(negedge clk);
    chk32(tag, inst_s, exp);
  endtask

  initial begin
    // reset values
    #3;
    chk1("rst_ready", ld_ready, 1'b0);
    chk1("rst_done", ld_done, 1'b0);
    chk1("rst_core_rst", core_rst, 1'b1);
    chk1("rst_ovf", ld_ovf, 1'b0);
    chk1("rst_fetch_err", fetch_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single-word load
    start();
    chk1("t1_ready", ld_ready, 1'b1);
    chk1("t1_core_rst_load", core_rst, 1'b1);
    send(8'h34, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b1);
    chk1("t1_done", ld_done, 1'b1);
    chk1("t1_core_rst_run", core_rst, 1'b0);
    chk1("t1_ready_run", ld_ready, 1'b0);
    fetch(32'h0, 32'h3401_0001, "t1_inst0");
    tick();
    chk1("t1_done_clear", ld_done, 1'b0);

    // nine bytes back to back, last word padded
    ce = 1'b0;
    start();
    for (int i = 1; i <= 9; i++) send(8'(i), (i == 9));
    chk1("t2_done", ld_done, 1'b1);
    fetch(32'h0, 32'h0102_0304, "t2_inst0");
    fetch(32'h4, 32'h0506_0708, "t2_inst1");
    fetch(32'h8, 32'h0900_0000, "t2_inst2");

    // valid toggling every other cycle, junk byte while idle
    start();
    for (int i = 1; i <= 9; i++) begin
      chk1("t3_ready", ld_ready, 1'b1);
      send(8'(8'h10 + i), (i == 9));
      if (i != 9) begin
        ld_byte = 8'hEE;
        tick();
      end
    end
    chk1("t3_done", ld_done, 1'b1);
    fetch(32'h0, 32'h1112_1314, "t3_inst0");
    fetch(32'h4, 32'h1516_1718, "t3_inst1");
    fetch(32'h8, 32'h1900_0000, "t3_inst2");

    // fetch errors
    fetch(32'h0000_1000, 32'h0, "t4_oor_inst");
    tick();
    chk1("t4_oor_err", fetch_err, 1'b1);
    ce = 1'b0;
    start();
    chk1("t4_err_cleared", fetch_err, 1'b0);
    fetch(32'h0000_0002, 32'h0, "t4_misalign_inst");
    tick();
    chk1("t4_misalign_err", fetch_err, 1'b1);
    ce   = 1'b0;
    addr = 32'h0;
    @(negedge clk);
    chk32("t4_ce0_inst", inst, 32'h0);

    // overflow on the 4-word instance
    start();
    for (int i = 0; i < 20; i++) send(8'(i), (i == 19));
    chk1("t5_done_s", ld_done_s, 1'b1);
    chk1("t5_ovf_s", ld_ovf_s, 1'b1);
    chk1("t5_ovf_main", ld_ovf, 1'b0);
    fetch_s(32'h0, 32'h0001_0203, "t5_s_inst0");
    fetch_s(32'hC, 32'h0C0D_0E0F, "t5_s_inst3");
    fetch(32'h10, 32'h1011_1213, "t5_main_inst4");

    // reset in the middle of a load
    ce = 1'b0;
    start();
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'b0);
    rst = 1'b1;
    #1;
    chk1("t6_core_rst", core_rst, 1'b1);
    chk1("t6_ready", ld_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0, 32'hA0A1_A2A3, "t6_retained0");
    fetch(32'h4, 32'h0405_0607, "t6_partial_lost");
    start();
    send(8'hB0, 1'b0);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b1);
    chk1("t6_done", ld_done, 1'b1);
    fetch(32'h0, 32'hB0B1_B2B3, "t6_restart0");

    // ld_start coinciding with a valid byte
    ce = 1'b0;
    start();
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    ld_start = 1'b1;
    ld_byte  = 8'hFF;
    ld_valid = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk1("t7_ready", ld_ready, 1'b1);
    send(8'hD0, 1'b0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b1);
    chk1("t7_done", ld_done, 1'b1);
    fetch(32'h0, 32'hD0D1_D2D3, "t7_inst0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
